// File: rtl/qspi_axi_bridge_pkg.sv
// rtl/qspi_axi_bridge_pkg.sv - shared widths, codes and FSM states for the QSPI AXI bridge
package qspi_axi_bridge_pkg;

    localparam int QSPI_CMD_LEN   = 8;
    localparam int QSPI_ADDR_LEN  = 32;
    localparam int QSPI_WDATA_LEN = 32;
    localparam int QSPI_START_LEN = 1;
    localparam int QSPI_RDATA_LEN = 32;
    localparam int QSPI_IDLE_LEN  = 1;
    localparam int TIMER_W        = 16;

    localparam logic [QSPI_CMD_LEN-1:0] DEF_CMD_WREG = 8'h02;
    localparam logic [QSPI_CMD_LEN-1:0] DEF_CMD_RREG = 8'h03;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_WRESP,
        S_RRESP
    } state_t;

    // Clamp a cycle-count parameter into the timer range so huge values saturate rather than wrap.
    function automatic logic [TIMER_W-1:0] timer_limit(input int cycles);
        if (cycles <= 0) return '0;
        if (cycles >= (1 << TIMER_W) - 1) return '1;
        return TIMER_W'(cycles);
    endfunction

    function automatic logic [TIMER_W-1:0] timer_inc(input logic [TIMER_W-1:0] t);
        return (t == '1) ? t : t + TIMER_W'(1);
    endfunction

endpackage

// File: rtl/qspi_axi_bridge_if.sv
// rtl/qspi_axi_bridge_if.sv - AXI4-Lite register bus between the CPU and the QSPI bridge
interface qspi_axi_bridge_if;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/qspi_axi_bridge.sv
// rtl/qspi_axi_bridge.sv - AXI4-Lite slave issuing one QSPI register transaction per access
module qspi_axi_bridge
    import qspi_axi_bridge_pkg::*;
#(
    parameter logic [QSPI_CMD_LEN-1:0] CMD_WREG     = DEF_CMD_WREG,
    parameter logic [QSPI_CMD_LEN-1:0] CMD_RREG     = DEF_CMD_RREG,
    parameter int                      ACK_TIMEOUT  = 16,
    parameter int                      DONE_TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    qspi_axi_bridge_if.slave          s_axi,
    output logic [QSPI_CMD_LEN-1:0]   qspi_cmd,
    output logic [QSPI_ADDR_LEN-1:0]  qspi_addr,
    output logic [QSPI_WDATA_LEN-1:0] qspi_wdata,
    output logic [QSPI_START_LEN-1:0] qspi_start,
    input  logic [QSPI_RDATA_LEN-1:0] qspi_rdata,
    input  logic [QSPI_IDLE_LEN-1:0]  qspi_idle
);

    localparam logic [TIMER_W-1:0] ACK_LIMIT  = timer_limit(ACK_TIMEOUT);
    localparam logic [TIMER_W-1:0] DONE_LIMIT = timer_limit(DONE_TIMEOUT);

    state_t state, state_next;

    logic [QSPI_CMD_LEN-1:0]   cmd_q;
    logic [QSPI_ADDR_LEN-1:0]  addr_q;
    logic [QSPI_WDATA_LEN-1:0] wdata_q;
    logic [31:0]               rdata_q;
    logic [1:0]                resp_q;
    logic [TIMER_W-1:0]        timer;
    logic                      is_read;
    logic                      write_prio;

    logic idle_now;
    logic wr_pend;
    logic rd_pend;
    logic grant_wr;
    logic grant_rd;
    logic start_c;
    logic unused_bits;

    assign idle_now    = qspi_idle[0];
    assign wr_pend     = s_axi.awvalid && s_axi.wvalid;
    assign rd_pend     = s_axi.arvalid;
    assign unused_bits = ^{s_axi.wstrb, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    assign qspi_cmd    = cmd_q;
    assign qspi_addr   = addr_q;
    assign qspi_wdata  = wdata_q;
    assign qspi_start  = QSPI_START_LEN'(start_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        grant_wr       = 1'b0;
        grant_rd       = 1'b0;
        start_c        = 1'b0;
        s_axi.awready  = 1'b0;
        s_axi.wready   = 1'b0;
        s_axi.arready  = 1'b0;
        s_axi.bvalid   = 1'b0;
        s_axi.rvalid   = 1'b0;
        s_axi.bresp    = resp_q;
        s_axi.rresp    = resp_q;
        s_axi.rdata    = rdata_q;

        case (state)
            S_IDLE: begin
                // Readies follow the grant so AW and W always handshake together and a losing AR waits.
                if (!reset) begin
                    grant_wr = wr_pend && (write_prio || !rd_pend);
                    grant_rd = rd_pend && !grant_wr;
                end
                s_axi.awready = grant_wr;
                s_axi.wready  = grant_wr;
                s_axi.arready = grant_rd;
                if (grant_wr || grant_rd) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (idle_now) begin
                    start_c    = 1'b1;
                    state_next = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (!idle_now) begin
                    state_next = S_WAIT_DONE;
                end else if (timer >= ACK_LIMIT) begin
                    state_next = is_read ? S_RRESP : S_WRESP;
                end
            end
            S_WAIT_DONE: begin
                if (idle_now || (timer >= DONE_LIMIT)) begin
                    state_next = is_read ? S_RRESP : S_WRESP;
                end
            end
            S_WRESP: begin
                s_axi.bvalid = 1'b1;
                if (s_axi.bready) begin
                    state_next = S_IDLE;
                end
            end
            S_RRESP: begin
                s_axi.rvalid = 1'b1;
                if (s_axi.rready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            resp_q     <= RESP_OKAY;
            timer      <= '0;
            is_read    <= 1'b0;
            write_prio <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_wr) begin
                        cmd_q   <= CMD_WREG;
                        addr_q  <= QSPI_ADDR_LEN'(s_axi.awaddr[31:2]);
                        wdata_q <= QSPI_WDATA_LEN'(s_axi.wdata);
                        is_read <= 1'b0;
                    end else if (grant_rd) begin
                        cmd_q   <= CMD_RREG;
                        addr_q  <= QSPI_ADDR_LEN'(s_axi.araddr[31:2]);
                        wdata_q <= '0;
                        is_read <= 1'b1;
                    end
                    if (grant_wr || grant_rd) begin
                        write_prio <= ~write_prio;
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                end
                S_WAIT_ACK: begin
                    if (!idle_now) begin
                        timer <= '0;
                    end else if (timer >= ACK_LIMIT) begin
                        resp_q  <= RESP_SLVERR;
                        rdata_q <= ERR_RDATA;
                    end else begin
                        timer <= timer_inc(timer);
                    end
                end
                S_WAIT_DONE: begin
                    if (idle_now) begin
                        resp_q <= RESP_OKAY;
                        if (is_read) begin
                            rdata_q <= qspi_rdata[31:0];
                        end
                    end else if (timer >= DONE_LIMIT) begin
                        resp_q  <= RESP_SLVERR;
                        rdata_q <= ERR_RDATA;
                    end else begin
                        timer <= timer_inc(timer);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_axi_bridge.sv
// tb/tb_qspi_axi_bridge.sv - directed scoreboard bench for qspi_axi_bridge
module tb_qspi_axi_bridge;
    import qspi_axi_bridge_pkg::*;

    localparam int ACK_TO  = 16;
    localparam int DONE_TO = 4096;

    typedef enum int {MGR_NORMAL, MGR_NOACK, MGR_STUCK} mgr_mode_t;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
    } issue_t;

    typedef struct {
        logic        is_read;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } resp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    qspi_axi_bridge_if axi();

    logic [QSPI_CMD_LEN-1:0]   qspi_cmd;
    logic [QSPI_ADDR_LEN-1:0]  qspi_addr;
    logic [QSPI_WDATA_LEN-1:0] qspi_wdata;
    logic [QSPI_START_LEN-1:0] qspi_start;
    logic [QSPI_RDATA_LEN-1:0] qspi_rdata = '0;
    logic [QSPI_IDLE_LEN-1:0]  qspi_idle  = '1;

    qspi_axi_bridge #(
        .ACK_TIMEOUT  (ACK_TO),
        .DONE_TIMEOUT (DONE_TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_axi      (axi),
        .qspi_cmd   (qspi_cmd),
        .qspi_addr  (qspi_addr),
        .qspi_wdata (qspi_wdata),
        .qspi_start (qspi_start),
        .qspi_rdata (qspi_rdata),
        .qspi_idle  (qspi_idle)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    issue_t exp_issue_q[$];
    resp_t  exp_resp_q[$];

    int start_count = 0;
    int start_cyc = 0;
    int aw_cyc = 0;
    int ar_cyc = 0;
    int b_cyc = 0;
    int r_cyc = 0;

    mgr_mode_t   mgr_mode = MGR_NORMAL;
    int          busy_len = 4;
    logic [31:0] mgr_rdata = '0;
    int          release_req = 0;
    int          release_ack = 0;
    int          busy_left = 0;
    logic        mgr_busy = 1'b0;
    int          idle_rise_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_issue(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
        issue_t e;
        e.cmd = c; e.addr = a; e.wdata = d;
        exp_issue_q.push_back(e);
    endtask

    task automatic push_resp(input logic rd, input logic [1:0] r, input logic [31:0] d);
        resp_t e;
        e.is_read = rd; e.resp = r; e.rdata = d;
        exp_resp_q.push_back(e);
    endtask

    task automatic check_resp(input string tag, input logic rd, input logic [1:0] r, input logic [31:0] d);
        resp_t e;
        check({tag, "_resp_expected"}, 32'(exp_resp_q.size() != 0), 32'd1);
        if (exp_resp_q.size() != 0) begin
            e = exp_resp_q.pop_front();
            check({tag, "_resp_kind"}, 32'(rd), 32'(e.is_read));
            check({tag, "_resp_code"}, 32'(r), 32'(e.resp));
            if (e.is_read) check({tag, "_rdata"}, d, e.rdata);
        end
    endtask

    // Model of qspi_manager: sees the start strobe mid-cycle and reacts just after the next edge.
    always begin : manager
        logic saw;
        @(negedge clk);
        saw = qspi_start[0];
        @(posedge clk);
        #1;
        if (release_req != release_ack) begin
            release_ack   = release_req;
            mgr_busy      = 1'b0;
            qspi_idle     = '1;
            idle_rise_cyc = cyc;
        end else if (saw && mgr_mode == MGR_NORMAL) begin
            qspi_idle = '0;
            mgr_busy  = 1'b1;
            busy_left = busy_len;
        end else if (saw && mgr_mode == MGR_STUCK) begin
            qspi_idle = '0;
        end else if (mgr_busy) begin
            busy_left--;
            if (busy_left <= 0) begin
                mgr_busy      = 1'b0;
                qspi_rdata    = mgr_rdata;
                qspi_idle     = '1;
                idle_rise_cyc = cyc;
            end
        end
    end

    always @(negedge clk) begin : start_monitor
        issue_t e;
        if (!reset && qspi_start[0]) begin
            start_count++;
            start_cyc = cyc;
            check("start_expected", 32'(exp_issue_q.size() != 0), 32'd1);
            if (exp_issue_q.size() != 0) begin
                e = exp_issue_q.pop_front();
                check("issue_cmd", 32'(qspi_cmd), 32'(e.cmd));
                check("issue_addr", 32'(qspi_addr), e.addr);
                check("issue_wdata", 32'(qspi_wdata), e.wdata);
            end
        end
    end

    task automatic run_ops(input int n_resp, input int limit, input string tag);
        int got = 0;
        for (int i = 0; i < limit && got < n_resp; i++) begin
            logic aw_hs, ar_hs;
            @(negedge clk);
            aw_hs = axi.awvalid && axi.awready && axi.wvalid && axi.wready;
            ar_hs = axi.arvalid && axi.arready;
            if (aw_hs) aw_cyc = cyc;
            if (ar_hs) ar_cyc = cyc;
            if (axi.bvalid && axi.bready) begin
                b_cyc = cyc;
                check_resp(tag, 1'b0, axi.bresp, 32'h0);
                got++;
            end
            if (axi.rvalid && axi.rready) begin
                r_cyc = cyc;
                check_resp(tag, 1'b1, axi.rresp, axi.rdata);
                got++;
            end
            @(posedge clk);
            #1;
            if (aw_hs) begin axi.awvalid = 1'b0; axi.wvalid = 1'b0; end
            if (ar_hs) axi.arvalid = 1'b0;
        end
        check({tag, "_responses"}, 32'(got), 32'(n_resp));
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int sc0;
        int nb;
        int d;

        axi.awaddr = '0; axi.wdata = '0; axi.wstrb = 4'hF; axi.araddr = '0;
        axi.bready = 1'b1; axi.rready = 1'b1;
        reset = 1'b1;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_readies", 32'({axi.awready, axi.wready, axi.arready}), 32'd0);
        check("reset_valids", 32'({axi.bvalid, axi.rvalid, qspi_start[0]}), 32'd0);
        check("reset_resp", 32'({axi.bresp, axi.rresp}), 32'd0);
        check("reset_rdata", axi.rdata, 32'd0);
        check("reset_qspi_fields", 32'(qspi_cmd) | qspi_addr | qspi_wdata, 32'd0);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Write 0x10 <- 0x12345678, manager busy 20 clks
        mgr_mode = MGR_NORMAL; busy_len = 20;
        push_issue(8'h02, 32'h4, 32'h1234_5678);
        push_resp(1'b0, 2'b00, 32'h0);
        sc0 = start_count;
        axi.awaddr = 32'h10; axi.wdata = 32'h1234_5678; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        run_ops(1, 200, "wr1");
        check("wr1_start_pulses", 32'(start_count - sc0), 32'd1);
        check("wr1_start_latency", 32'(start_cyc - aw_cyc), 32'd1);
        check("wr1_b_latency", 32'(b_cyc - idle_rise_cyc), 32'd1);

        // Read 0x20 returning 0xCAFEF00D
        busy_len = 5; mgr_rdata = 32'hCAFE_F00D;
        push_issue(8'h03, 32'h8, 32'h0);
        push_resp(1'b1, 2'b00, 32'hCAFE_F00D);
        sc0 = start_count;
        axi.araddr = 32'h20; axi.arvalid = 1'b1;
        run_ops(1, 200, "rd1");
        check("rd1_start_pulses", 32'(start_count - sc0), 32'd1);
        check("rd1_start_latency", 32'(start_cyc - ar_cyc), 32'd1);
        check("rd1_r_latency", 32'(r_cyc - idle_rise_cyc), 32'd1);

        // Simultaneous AW+W+AR right after reset: write wins
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        busy_len = 3; mgr_rdata = 32'h3333_4444;
        push_issue(8'h02, 32'hC, 32'h1111_2222);
        push_issue(8'h03, 32'hD, 32'h0);
        push_resp(1'b0, 2'b00, 32'h0);
        push_resp(1'b1, 2'b00, 32'h3333_4444);
        sc0 = start_count;
        axi.awaddr = 32'h30; axi.wdata = 32'h1111_2222; axi.araddr = 32'h34;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
        run_ops(2, 300, "both1");
        check("both1_start_pulses", 32'(start_count - sc0), 32'd2);
        check("both1_write_first", 32'(ar_cyc > aw_cyc), 32'd1);

        // Manager never acknowledges a read
        mgr_mode = MGR_NOACK;
        push_issue(8'h03, 32'h10, 32'h0);
        push_resp(1'b1, 2'b10, 32'hDEAD_BEEF);
        axi.araddr = 32'h40; axi.arvalid = 1'b1;
        run_ops(1, 200, "ackto");
        d = r_cyc - start_cyc;
        check("ackto_window", 32'(d >= ACK_TO && d <= ACK_TO + 3), 32'd1);

        // Manager stuck busy on a write, then a normal write afterwards
        mgr_mode = MGR_STUCK;
        push_issue(8'h02, 32'h20, 32'hA5A5_5A5A);
        push_resp(1'b0, 2'b10, 32'h0);
        axi.awaddr = 32'h80; axi.wdata = 32'hA5A5_5A5A; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        run_ops(1, DONE_TO + 200, "doneto");
        d = b_cyc - start_cyc;
        check("doneto_window", 32'(d >= DONE_TO && d <= DONE_TO + 10), 32'd1);
        release_req++;
        repeat (3) @(posedge clk);
        #1;
        mgr_mode = MGR_NORMAL; busy_len = 4;
        push_issue(8'h02, 32'h21, 32'h0BAD_CAFE);
        push_resp(1'b0, 2'b00, 32'h0);
        axi.awaddr = 32'h84; axi.wdata = 32'h0BAD_CAFE; axi.wstrb = 4'h1;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        run_ops(1, 200, "wr_after_to");
        axi.wstrb = 4'hF;

        // Reset while the manager is busy: the write is abandoned silently
        busy_len = 40;
        push_issue(8'h02, 32'h40, 32'hFEED_0001);
        sc0 = start_count;
        axi.awaddr = 32'h100; axi.wdata = 32'hFEED_0001; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (axi.awready) break;
        end
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_started", 32'(start_count - sc0), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_valids", 32'({axi.bvalid, axi.rvalid, qspi_start[0]}), 32'd0);
        check("abort_qspi_fields", 32'(qspi_cmd) | qspi_addr | qspi_wdata, 32'd0);
        check("abort_resp_rdata", 32'({axi.bresp, axi.rresp}) | axi.rdata, 32'd0);
        nb = 0;
        repeat (60) begin
            @(negedge clk);
            if (axi.bvalid || axi.rvalid) nb++;
        end
        check("abort_no_response", 32'(nb), 32'd0);
        @(posedge clk); #1;

        push_issue(8'h02, 32'h41, 32'h0000_0005);
        push_resp(1'b0, 2'b00, 32'h0);
        busy_len = 3;
        axi.awaddr = 32'h104; axi.wdata = 32'h0000_0005; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        run_ops(1, 200, "wr_after_reset");

        // Write was granted last, so a simultaneous pair now goes read first
        mgr_rdata = 32'h9999_AAAA;
        push_issue(8'h03, 32'h14, 32'h0);
        push_issue(8'h02, 32'h15, 32'h7777_8888);
        push_resp(1'b1, 2'b00, 32'h9999_AAAA);
        push_resp(1'b0, 2'b00, 32'h0);
        axi.araddr = 32'h50; axi.awaddr = 32'h54; axi.wdata = 32'h7777_8888;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
        run_ops(2, 300, "both2");
        check("both2_read_first", 32'(ar_cyc < aw_cyc), 32'd1);

        repeat (2) @(posedge clk);
        check("issue_q_drained", 32'(exp_issue_q.size()), 32'd0);
        check("resp_q_drained", 32'(exp_resp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
